pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central pipeline-register controller for the 5-stage RV32I core.
- Drives the load and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC load.
- Consumes the ID/EX register outputs (EX-stage rd and mem_read), the IF/ID source registers, the EX branch decision, and the instruction/data memory handshakes.
- Resolves memory freezes, load-use bubbles and branch flushes. Keeps performance counters and a memory-timeout watchdog.

Parameters:
CNT_W, 32, width of the stall_cycles and bubble_cycles counters
TIMEOUT, 1024, consecutive freeze cycles before mem_timeout is set (must be at least 1)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
imem_req  input  1  fetch stage has an outstanding instruction read
imem_resp  input  1  instruction memory response; one-cycle pulse
dmem_req  input  1  MEM stage has an outstanding load or store
dmem_resp  input  1  data memory response; one-cycle pulse
ex_mem_read  input  1  ctrl_word_out.mem_read from the ID/EX register
ex_rd  input  5  rd_out from the ID/EX register
id_rs1  input  5  rs1 of the instruction held in IF/ID
id_rs2  input  5  rs2 of the instruction held in IF/ID
ex_br_taken  input  1  EX stage redirects the PC (taken branch or jump)
load_pc  output  1  PC register load enable
load_if_id  output  1  IF/ID load enable
load_id_ex  output  1  ID/EX load enable
load_ex_mem  output  1  EX/MEM load enable
load_mem_wb  output  1  MEM/WB load enable
flush_if_id  output  1  IF/ID loads a NOP instead of its input
flush_id_ex  output  1  ID/EX loads a zero control word
stall_cycles  output  CNT_W  count of freeze cycles
bubble_cycles  output  CNT_W  count of load-use bubbles inserted
mem_timeout  output  1  sticky flag: a freeze lasted TIMEOUT cycles

Behaviour:
- Reset (rst low, asynchronous):
  - i_done, d_done, freeze_cnt, stall_cycles, bubble_cycles and mem_timeout clear to 0.
  - Every load and flush output is forced to 0 while rst is low.
- Latched-response flags:
  - i_done is set when imem_resp pulses while freeze=1. d_done is set likewise on dmem_resp.
  - Both flags clear on any cycle with freeze=0.
  - A response that arrives while the other side is still pending is therefore not lost.
- i_ok = ~imem_req | imem_resp | i_done. d_ok = ~dmem_req | dmem_resp | d_done.
- freeze = ~(i_ok & d_ok). It is combinational, so there are zero cycles of added latency.
- While freeze=1: all five loads and both flushes are 0; the whole pipeline holds its contents.
- hazard = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- Priority when freeze=0:
  1. ex_br_taken:
     - all loads 1; flush_if_id=1 and flush_id_ex=1.
     - hazard is ignored because the dependent instruction is squashed.
  2. hazard:
     - load_pc=0, load_if_id=0; load_id_ex, load_ex_mem and load_mem_wb are 1.
     - flush_id_ex=1 (one bubble); flush_if_id=0.
  3. Otherwise: all loads 1, both flushes 0.
- A hazard lasts exactly one cycle: after the bubble, ID/EX holds a zero control word, so ex_mem_read=0.
- Counters:
  - stall_cycles += 1 on each freeze cycle.
  - bubble_cycles += 1 on each priority-2 cycle.
  - Both wrap modulo 2^CNT_W.
- Watchdog:
  - freeze_cnt increments on each freeze cycle and clears to 0 on each non-freeze cycle.
  - When freeze_cnt reaches TIMEOUT-1 during a freeze cycle, mem_timeout is set on that edge.
  - mem_timeout is sticky and is cleared only by reset.
  - freeze_cnt saturates at TIMEOUT-1.
- Both responses arriving in the same cycle, with both requests pending: freeze=0 that cycle and the pipeline advances.
- A response pulse without a matching request: no effect on freeze. The flag may set, but it clears on the next non-freeze cycle.
- Reset asserted mid-freeze: the flags are discarded and there is no residual stall after reset release.

Test Plan:
- Reset then idle: rst low, then high; all requests 0 -> all loads 1, flushes 0, counters 0, mem_timeout 0.
- Data miss:
  - Stimulus: dmem_req=1 held, dmem_resp pulses on cycle 4.
  - Required: loads 0 for cycles 0-3, all 1 on cycle 4; stall_cycles=4.
- Split responses:
  - Stimulus: imem_req and dmem_req both held 1; imem_resp pulses at cycle 2, dmem_resp at cycle 6.
  - Required: freeze through cycle 5, advance on cycle 6; i_done set cycles 3-6 and clear after cycle 6.
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs2=5.
  - Required: one cycle with load_pc=0, load_if_id=0, flush_id_ex=1; bubble_cycles=1. Then with ex_mem_read=0, normal advance.
- x0 and branch priority:
  - Stimulus A: ex_rd=0, id_rs1=0, ex_mem_read=1 -> no stall.
  - Stimulus B: hazard together with ex_br_taken=1 -> all loads 1, both flushes 1, bubble_cycles unchanged.
- Timeout: TIMEOUT=8, imem_req held with no resp -> mem_timeout rises after 8 freeze cycles, stays 1 after resp; cleared only by rst low.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline-register controller for the 5-stage RV32I core: memory freezes,
// load-use bubbles, branch flushes, performance counters and a freeze watchdog.
module pipeline_stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cycles,
  output logic             mem_timeout
);

  localparam int FC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(TIMEOUT - 1);

  logic            i_done_r;
  logic            d_done_r;
  logic [FC_W-1:0] freeze_cnt_r;
  logic            i_ok_s;
  logic            d_ok_s;
  logic            freeze_s;
  logic            hazard_s;
  logic            bubble_s;

  assign i_ok_s   = ~imem_req | imem_resp | i_done_r;
  assign d_ok_s   = ~dmem_req | dmem_resp | d_done_r;
  assign freeze_s = ~(i_ok_s & d_ok_s);
  assign hazard_s = ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign bubble_s = ~freeze_s & ~ex_br_taken & hazard_s;

  // Load/flush decode; combinational so a freeze takes effect in the same cycle.
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst || freeze_s) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end else if (ex_br_taken) begin
      // The redirect squashes the dependent instruction, so the hazard is moot.
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard_s) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  // Latch responses that arrive while the other side is still pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
    end else if (freeze_s) begin
      i_done_r <= i_done_r | imem_resp;
      d_done_r <= d_done_r | dmem_resp;
    end else begin
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= {CNT_W{1'b0}};
      bubble_cycles <= {CNT_W{1'b0}};
    end else begin
      if (freeze_s) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (bubble_s) begin
        bubble_cycles <= bubble_cycles + CNT_W'(1);
      end else begin
        bubble_cycles <= bubble_cycles;
      end
    end
  end

  // Watchdog: saturating run-length of the current freeze, sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freeze_cnt_r <= {FC_W{1'b0}};
      mem_timeout  <= 1'b0;
    end else if (freeze_s) begin
      if (freeze_cnt_r == FC_MAX) begin
        freeze_cnt_r <= freeze_cnt_r;
        mem_timeout  <= 1'b1;
      end else begin
        freeze_cnt_r <= freeze_cnt_r + FC_W'(1);
        mem_timeout  <= mem_timeout;
      end
    end else begin
      freeze_cnt_r <= {FC_W{1'b0}};
      mem_timeout  <= mem_timeout;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios plus random traffic.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_req = 1'b0, imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
  logic ex_mem_read = 1'b0, ex_br_taken = 1'b0;
  logic [4:0] ex_rd = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, bubble_cycles;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_br_taken(ex_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       loads;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [1:0]       flushes; // if_id, id_ex
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] bubble;
    logic             tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state, tracked independently of the DUT.
  logic             m_idone = 1'b0, m_ddone = 1'b0, m_tmo = 1'b0;
  int               m_run = 0;
  logic [CNT_W-1:0] m_stall = '0, m_bubble = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and push the expectation.
  task automatic step(input logic r, input logic ireq, input logic iresp,
                      input logic dreq, input logic dresp, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br);
    exp_t e;
    logic frz, haz;
    @(posedge clk);
    #1;
    rst = r; imem_req = ireq; imem_resp = iresp; dmem_req = dreq; dmem_resp = dresp;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; ex_br_taken = br;
    if (!r) begin
      m_idone = 1'b0; m_ddone = 1'b0; m_tmo = 1'b0; m_run = 0;
      m_stall = '0; m_bubble = '0;
    end
    frz = !((!ireq || iresp || m_idone) && (!dreq || dresp || m_ddone));
    haz = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    e.stall = m_stall; e.bubble = m_bubble; e.tmo = m_tmo;
    if (!r || frz)  begin e.loads = 5'b00000; e.flushes = 2'b00; end
    else if (br)    begin e.loads = 5'b11111; e.flushes = 2'b11; end
    else if (haz)   begin e.loads = 5'b00111; e.flushes = 2'b01; end
    else            begin e.loads = 5'b11111; e.flushes = 2'b00; end
    exp_q.push_back(e);
    if (r) begin
      if (frz) begin
        m_idone = m_idone | iresp;
        m_ddone = m_ddone | dresp;
        m_stall = m_stall + 1;
        m_run++;
        if (m_run >= TIMEOUT) m_tmo = 1'b1;
      end else begin
        m_idone = 1'b0; m_ddone = 1'b0; m_run = 0;
        if (!br && haz) m_bubble = m_bubble + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Pop and compare one expectation per cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("loads",  {59'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, {59'd0, e.loads});
      check("flushes", {62'd0, flush_if_id, flush_id_ex}, {62'd0, e.flushes});
      check("stall_cycles",  {32'd0, stall_cycles},  {32'd0, e.stall});
      check("bubble_cycles", {32'd0, bubble_cycles}, {32'd0, e.bubble});
      check("mem_timeout", {63'd0, mem_timeout}, {63'd0, e.tmo});
    end
  end

  initial begin
    // Reset then idle
    do_reset();
    idle(3);

    // Data miss: four frozen cycles, response on the fifth
    for (int c = 0; c < 4; c++) step(1'b1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1'b1, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    @(negedge clk);
    check("miss_stall_total", {32'd0, stall_cycles}, 64'd4);

    // Split responses: imem at cycle 2, dmem at cycle 6
    do_reset();
    for (int c = 0; c <= 6; c++)
      step(1'b1, 1, (c == 2), 1, (c == 6), 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    check("split_advance", {59'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 64'h1f);
    step(1'b1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0); // i_done must have cleared
    idle(1);
    @(negedge clk);
    check("split_stall_total", {32'd0, stall_cycles}, 64'd7);

    // Load-use bubble then normal advance
    do_reset();
    step(1'b1, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
    step(1'b1, 0, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5, 0);
    @(negedge clk);
    check("loaduse_bubble_total", {32'd0, bubble_cycles}, 64'd1);
    step(1'b1, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0); // rs1 match also stalls
    // x0 never stalls; branch overrides hazard
    step(1'b1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    step(1'b1, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd3, 1);
    idle(1);
    @(negedge clk);
    check("branch_bubble_total", {32'd0, bubble_cycles}, 64'd2);

    // Timeout: flag rises after TIMEOUT frozen cycles and is sticky
    do_reset();
    for (int c = 0; c < TIMEOUT + 3; c++) step(1'b1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1'b1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    @(negedge clk);
    check("timeout_sticky", {63'd0, mem_timeout}, 64'd1);
    // Reset mid-freeze leaves no residual stall
    step(1'b1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1'b1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    do_reset();
    step(1'b1, 1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    @(negedge clk);
    check("timeout_cleared", {63'd0, mem_timeout}, 64'd0);

    // Random traffic; register numbers kept small so hazards are common
    for (int c = 0; c < 400; c++)
      step(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0);
    idle(2);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
